texture_mem: RTL
================

TEXTURE_MEM -- requirements
Module: texture_mem

Interface
REQ-001 Parameter CHANNEL_BITS, default 2: bits per colour channel; texel width W = 3*CHANNEL_BITS.
REQ-002 Parameter TEX_BITS, default 1: texture-select width; 2^TEX_BITS textures.
REQ-003 Parameter SIZE_BITS, default 6: texture edge is 2^SIZE_BITS texels; col and row are each SIZE_BITS wide.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 rd_req  in  1  read request; accepted when rd_req && rd_ready.
REQ-007 rd_tex / rd_col / rd_row  in  TEX_BITS / SIZE_BITS / SIZE_BITS  read texel coordinates.
REQ-008 rd_dim  in  1  dim request for this read (see Configuration).
REQ-009 rd_ready  out  1  read port can accept; equals !load_busy.
REQ-010 rd_valid  out  1  rd_val holds the result of an accepted read.
REQ-011 rd_val  out  W  texel, {R,G,B}, each CHANNEL_BITS, R in the MSBs.
REQ-012 load_start  in  1  begin loading one texture.
REQ-013 load_tex  in  TEX_BITS  texture to load, sampled with load_start.
REQ-014 load_valid / load_data  in  1 / W  load stream beat.
REQ-015 load_ready  out  1  loader accepts a beat this cycle.
REQ-016 load_busy  out  1  loader in LOAD or DONE.
REQ-017 load_done  out  1  one-cycle pulse, texture fully written.

Function
REQ-018 Storage SHALL be 2^(TEX_BITS+2*SIZE_BITS) words of W bits, address {tex,col,row}, row in LSBs (Y scanned first, then X).
REQ-019 Read latency SHALL be exactly 2 cycles: request accepted at edge N -> rd_valid=1 with data after edge N+2.
REQ-020 Read pipeline SHALL accept one request per cycle, fully pipelined, results in order.
REQ-021 rd_valid SHALL be 0 in cycles with no result; rd_val SHALL hold its last value while rd_valid=0.
REQ-022 rd_req while rd_ready=0 SHALL be ignored and produce no rd_valid.
REQ-023 Loader FSM states: IDLE, LOAD, DONE.
REQ-024 IDLE: load_start=1 -> LOAD; latch load_tex; beat counter := 0.
REQ-025 LOAD: load_ready=1; each load_valid beat writes load_data to {latched tex, counter} and increments counter.
REQ-026 Beat with counter = 2^(2*SIZE_BITS)-1 SHALL be the final beat: counter wraps to 0, FSM -> DONE.
REQ-027 DONE: load_done=1, load_ready=0 for one cycle, then -> IDLE.
REQ-028 load_start outside IDLE SHALL be ignored; load_valid outside LOAD SHALL be ignored.
REQ-029 load_start and rd_req together in IDLE: read accepted that cycle; rd_ready=0 from next cycle.
REQ-030 Reads already in the pipeline when loading starts SHALL complete with pre-load data.
REQ-031 Any read accepted after load_done SHALL return newly loaded data.
REQ-032 Textures other than the one being loaded SHALL remain unchanged.

Reset
REQ-033 With reset_n=0 at a clock edge: FSM := IDLE, counter := 0, pipeline valids := 0, rd_valid=0, rd_val=0, load_ready=0, load_busy=0, load_done=0.
REQ-034 Memory contents SHALL NOT be reset; reset mid-load aborts with no load_done, partially written texels retained.
REQ-035 In simulation, memory MAY be preloaded from the TEXTURE_FILE define; synthesis SHALL NOT rely on it.

Configuration
REQ-036 Macro TEXMEM_SHADE_EN defined: when rd_dim=1 at acceptance, each channel of rd_val is its stored value logically shifted right by 1 (e.g. 2'b11 -> 2'b01); latency unchanged.
REQ-037 TEXMEM_SHADE_EN undefined: rd_dim ignored; rd_val always equals the stored texel.

Verification
REQ-038 Reset then idle -> rd_valid=0, rd_val=0, load_busy=0, load_ready=0, rd_ready=1.
REQ-039 Load tex 1 with 4096 beats, data = beat index mod 64 -> load_done pulses once, one cycle after beat 4095; read tex1 col 2 row 5 -> rd_val=6'd5 two cycles later.
REQ-040 Back-to-back reads over 8 consecutive rows, one per cycle -> 8 consecutive rd_valid cycles, in order, each 2 cycles after its request.
REQ-041 load_start in the same cycle as rd_req, then rd_req during LOAD -> first read returns old data; LOAD-time reads produce no rd_valid; rd_ready=1 again after DONE.
REQ-042 reset_n=0 after 100 load beats, then a new full load of tex 0 -> no load_done from the aborted load; new load completes; tex 1 contents unchanged.
REQ-043 TEXMEM_SHADE_EN defined, texel 6'b111111, rd_dim=1 -> rd_val=6'b010101; macro undefined -> 6'b111111.

Source files
------------

// File: rtl/texture_mem.sv
// Multi-texture texel store with a streaming loader and a 2-cycle read pipeline.
// Optional TEXMEM_SHADE_EN halves each colour channel on reads with rd_dim set.
module texture_mem #(
    parameter int CHANNEL_BITS = 2,
    parameter int TEX_BITS     = 1,
    parameter int SIZE_BITS    = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        rd_req,
    input  logic [TEX_BITS-1:0]         rd_tex,
    input  logic [SIZE_BITS-1:0]        rd_col,
    input  logic [SIZE_BITS-1:0]        rd_row,
    input  logic                        rd_dim,
    output logic                        rd_ready,
    output logic                        rd_valid,
    output logic [3*CHANNEL_BITS-1:0]   rd_val,
    input  logic                        load_start,
    input  logic [TEX_BITS-1:0]         load_tex,
    input  logic                        load_valid,
    input  logic [3*CHANNEL_BITS-1:0]   load_data,
    output logic                        load_ready,
    output logic                        load_busy,
    output logic                        load_done
);
    localparam int W     = 3 * CHANNEL_BITS;
    localparam int CW    = 2 * SIZE_BITS;
    localparam int AW    = TEX_BITS + CW;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TEX_BITS-1:0] tex_q, tex_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ld_we;
    logic [AW-1:0]       wr_addr;

    logic                rd_acc;
    logic                s1_valid_q, s1_valid_d;
    logic [AW-1:0]       s1_addr_q, s1_addr_d;
    logic                s2_valid_q, s2_valid_d;
    logic [W-1:0]        s2_data_q, s2_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [W-1:0]        rd_val_q, rd_val_d;
    logic [W-1:0]        shade_val;

    logic [W-1:0]        mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        tex_d      = tex_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        load_busy  = 1'b1;
        load_done  = 1'b0;
        ld_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_busy = 1'b0;
                if (load_start) begin
                    state_d = LOAD;
                    tex_d   = load_tex;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    ld_we = reset_n;
                    cnt_d = cnt_q + 1'b1;
                    // Counter wraps to zero on the last texel of the texture
                    if (&cnt_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_addr  = {tex_q, cnt_q};
    assign rd_ready = !load_busy;
    assign rd_acc   = rd_req && rd_ready;

    always_comb begin
        s1_valid_d = rd_acc;
        s1_addr_d  = rd_acc ? {rd_tex, rd_col, rd_row} : s1_addr_q;
        s2_valid_d = s1_valid_q;
        s2_data_d  = mem[s1_addr_q];
        rd_valid_d = s2_valid_q;
        rd_val_d   = s2_valid_q ? shade_val : rd_val_q;
    end

`ifdef TEXMEM_SHADE_EN
    logic s1_dim_q, s1_dim_d;
    logic s2_dim_q, s2_dim_d;

    always_comb begin
        s1_dim_d = rd_acc ? rd_dim : s1_dim_q;
        s2_dim_d = s1_dim_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_dim_q <= 1'b0;
            s2_dim_q <= 1'b0;
        end else begin
            s1_dim_q <= s1_dim_d;
            s2_dim_q <= s2_dim_d;
        end
    end

    always_comb begin
        shade_val = s2_data_q;
        if (s2_dim_q) begin
            for (int i = 0; i < 3; i++) begin
                shade_val[i*CHANNEL_BITS +: CHANNEL_BITS] =
                    s2_data_q[i*CHANNEL_BITS +: CHANNEL_BITS] >> 1;
            end
        end
    end
`else
    logic unused_dim;
    assign unused_dim = rd_dim;

    always_comb begin
        shade_val = s2_data_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tex_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            tex_q      <= tex_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            rd_valid_q <= rd_valid_d;
            rd_val_q   <= rd_val_d;
        end
    end

    // Texel storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[wr_addr] <= load_data;
        end
        s2_data_q <= s2_data_d;
    end

    assign rd_valid = rd_valid_q;
    assign rd_val   = rd_val_q;

endmodule
